// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the registered N-to-1 scanning channel multiplexer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin scan pointer with programmable dwell; fires once per DWELL free cycles.
module mux_scan_ptr #(
  parameter  int unsigned CHANNELS = 8,
  parameter  int unsigned DWELL    = 1,
  localparam int unsigned SEL_W    = $clog2(CHANNELS),
  localparam int unsigned DCNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_adv,
  input  logic             i_free,
  output logic [SEL_W-1:0] o_ptr_c,
  output logic             o_fire_c
);

  logic [SEL_W-1:0]  r_ptr;
  logic [DCNT_W-1:0] r_dcnt;
  logic [SEL_W-1:0]  w_ptr;
  logic [DCNT_W-1:0] w_dcnt;
  logic              w_fire;

  // Clearing is applied combinationally so the entry cycle already counts toward the dwell.
  assign w_ptr  = i_clear ? '0 : r_ptr;
  assign w_dcnt = i_clear ? '0 : r_dcnt;
  assign w_fire = i_adv && i_free && (w_dcnt == DCNT_W'(DWELL - 1));

  assign o_ptr_c  = w_ptr;
  assign o_fire_c = w_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_dcnt <= '0;
    end else if (i_adv && i_free) begin
      if (w_fire) begin
        r_dcnt <= '0;
        r_ptr  <= (w_ptr == SEL_W'(CHANNELS - 1)) ? '0 : w_ptr + SEL_W'(1);
      end else begin
        r_dcnt <= w_dcnt + DCNT_W'(1);
        r_ptr  <= w_ptr;
      end
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-to-1 channel mux with manual and auto-scan selection and a valid/ready output.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int unsigned CHANNELS = 8,
  parameter  int unsigned WIDTH    = 1,
  parameter  int unsigned DWELL    = 1,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] i_in,
  input  logic                      i_en,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [WIDTH-1:0]          o_out_data,
  output logic [SEL_W-1:0]          o_out_sel,
  output logic                      o_out_err,
  output logic                      o_out_valid,
  input  logic                      i_out_ready
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  state_e           r_state;
  state_e           w_target;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel;
  logic             r_err;
  logic             r_valid;
  logic             w_free;
  logic             w_enter;
  logic             w_in_range;
  logic [SEL_W-1:0] w_ptr;
  logic             w_fire;

  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (idx == SEL_W'(k)) v = bus[k*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  always_comb begin
    w_target = ST_IDLE;
    if (i_en) w_target = (i_mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
  end

  assign w_free     = !r_valid || i_out_ready;
  assign w_enter    = (w_target == ST_SCAN) && (r_state != ST_SCAN);
  assign w_in_range = {1'b0, i_sel} < CH_LIM;

  mux_scan_ptr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_enter),
    .i_adv    (w_target == ST_SCAN),
    .i_free   (w_free),
    .o_ptr_c  (w_ptr),
    .o_fire_c (w_fire)
  );

  // State only advances with a free slot, so a stalled beat keeps the old mode in force.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_free) begin
      r_state <= w_target;
      case (w_target)
        ST_MANUAL: begin
          r_data  <= w_in_range ? pick(i_in, i_sel) : '0;
          r_sel   <= i_sel;
          r_err   <= !w_in_range;
          r_valid <= 1'b1;
        end
        ST_SCAN: begin
          if (w_fire) begin
            r_data  <= pick(i_in, w_ptr);
            r_sel   <= w_ptr;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign o_out_data  = r_data;
  assign o_out_sel   = r_sel;
  assign o_out_err   = r_err;
  assign o_out_valid = r_valid;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: two configurations (8ch/dwell 1 and 5ch/dwell 2) against a reference model.
module tb_mux_scan_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, ready;
  logic [2:0] sel;
  logic [7:0] in_a;
  logic [4:0] in_b;

  logic [0:0] a_data, b_data;
  logic [2:0] a_sel, b_sel;
  logic       a_err, b_err, a_valid, b_valid;

  always #5 clk = ~clk;

  mux_scan_n #(.CHANNELS(8), .WIDTH(1), .DWELL(1)) dut_a (
    .clk(clk), .rst(rst), .i_in(in_a), .i_en(en), .i_mode(mode), .i_sel(sel),
    .o_out_data(a_data), .o_out_sel(a_sel), .o_out_err(a_err),
    .o_out_valid(a_valid), .i_out_ready(ready)
  );

  mux_scan_n #(.CHANNELS(5), .WIDTH(1), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst), .i_in(in_b), .i_en(en), .i_mode(mode), .i_sel(sel),
    .o_out_data(b_data), .o_out_sel(b_sel), .o_out_err(b_err),
    .o_out_valid(b_valid), .i_out_ready(ready)
  );

  int total = 0;
  int bad   = 0;

  // Model state per DUT: held beat, last accepted activity (0 idle, 1 manual, 2 scan)
  // and number of free scan cycles elapsed since scan was entered.
  int m_valid[2], m_data[2], m_sel[2], m_err[2], m_prev[2], m_k[2];

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_data[i] = 0; m_sel[i] = 0; m_err[i] = 0;
      m_prev[i]  = 0; m_k[i]    = 0;
    end
  endtask

  function automatic int chan_bit(input int id, input int ch);
    return (id == 0) ? int'(in_a[ch]) : int'(in_b[ch]);
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    for (int id = 0; id < 2; id++) begin
      int c, d, tgt, cap;
      c = (id == 0) ? 8 : 5;
      d = (id == 0) ? 1 : 2;
      if (m_valid[id] == 0 || ready) begin
        tgt = !en ? 0 : (mode ? 2 : 1);
        if (tgt == 1) begin
          m_sel[id]   = int'(sel);
          m_err[id]   = (int'(sel) >= c) ? 1 : 0;
          m_data[id]  = (int'(sel) >= c) ? 0 : chan_bit(id, int'(sel));
          m_valid[id] = 1;
        end else if (tgt == 2) begin
          if (m_prev[id] != 2) m_k[id] = 0;
          if ((m_k[id] + 1) % d == 0) begin
            cap         = ((m_k[id] + 1) / d - 1) % c;
            m_sel[id]   = cap;
            m_data[id]  = chan_bit(id, cap);
            m_err[id]   = 0;
            m_valid[id] = 1;
          end else begin
            m_valid[id] = 0;
          end
          m_k[id]++;
        end else begin
          m_valid[id] = 0;
        end
        m_prev[id] = tgt;
      end
    end
  endtask

  task automatic check_models();
    chk("a_valid", int'(a_valid), m_valid[0]);
    chk("a_data",  int'(a_data),  m_data[0]);
    chk("a_sel",   int'(a_sel),   m_sel[0]);
    chk("a_err",   int'(a_err),   m_err[0]);
    chk("b_valid", int'(b_valid), m_valid[1]);
    chk("b_data",  int'(b_data),  m_data[1]);
    chk("b_sel",   int'(b_sel),   m_sel[1]);
    chk("b_err",   int'(b_err),   m_err[1]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_models();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_valid"}, int'(a_valid), 0);
    chk({tag, "_a_data"},  int'(a_data),  0);
    chk({tag, "_a_sel"},   int'(a_sel),   0);
    chk({tag, "_a_err"},   int'(a_err),   0);
    chk({tag, "_b_valid"}, int'(b_valid), 0);
    chk({tag, "_b_sel"},   int'(b_sel),   0);
  endtask

  typedef struct {
    logic       en;
    logic       mode;
    logic       ready;
    logic [2:0] sel;
    logic       exp_valid;
    logic       exp_data;
    logic [2:0] exp_sel;
    logic       exp_err;
  } vec_t;

  vec_t tab[6];
  int   saved;

  initial begin
    tab[0] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 3'd1, 1'b0};
    tab[1] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 3'd4, 1'b0};
    tab[2] = '{1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 3'd6, 1'b0};
    tab[3] = '{1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0};
    tab[4] = '{1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0};
    tab[5] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0};

    rst = 1'b1; en = 1'b0; mode = 1'b0; ready = 1'b1; sel = '0;
    in_a = 8'b1000_1010; in_b = 5'b1_0110;
    model_reset();
    #12;
    check_zero("reset");
    rst = 1'b0;

    // Manual selection on the 8-channel instance.
    for (int i = 0; i < 6; i++) begin
      en = tab[i].en; mode = tab[i].mode; ready = tab[i].ready; sel = tab[i].sel;
      tick();
      chk($sformatf("tab%0d_valid", i), int'(a_valid), int'(tab[i].exp_valid));
      chk($sformatf("tab%0d_data", i),  int'(a_data),  int'(tab[i].exp_data));
      chk($sformatf("tab%0d_sel", i),   int'(a_sel),   int'(tab[i].exp_sel));
      chk($sformatf("tab%0d_err", i),   int'(a_err),   int'(tab[i].exp_err));
    end

    // Out-of-range select on the 5-channel instance, including the first illegal value.
    en = 1'b1; mode = 1'b0; in_b = 5'b1_0110;
    sel = 3'd5; tick();
    chk("oor5_err", int'(b_err), 1); chk("oor5_data", int'(b_data), 0); chk("oor5_sel", int'(b_sel), 5);
    sel = 3'd6; tick();
    chk("oor6_err", int'(b_err), 1); chk("oor6_data", int'(b_data), 0); chk("oor6_sel", int'(b_sel), 6);
    sel = 3'd4; tick();
    chk("inr4_err", int'(b_err), 0); chk("inr4_data", int'(b_data), 1); chk("inr4_valid", int'(b_valid), 1);

    // Scan with wrap on 5 channels, dwell 2.
    mode = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      in_b = 5'($urandom);
      tick();
      if (t % 2 == 0) begin
        chk($sformatf("wrap%0d_valid", t), int'(b_valid), 1);
        chk($sformatf("wrap%0d_sel", t),   int'(b_sel),   (t / 2 - 1) % 5);
      end else begin
        chk($sformatf("wrap%0d_valid", t), int'(b_valid), 0);
      end
    end

    // Backpressure on the 8-channel scan: beat 2 must be held and the pointer frozen.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1; ready = 1'b1; in_a = 8'b0000_0100;
    repeat (3) tick();
    chk("bp_sel2", int'(a_sel), 2);
    saved = 1;
    ready = 1'b0; in_a = 8'h00;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("bp_hold_valid", int'(a_valid), 1);
      chk("bp_hold_sel",   int'(a_sel),   2);
      chk("bp_hold_data",  int'(a_data),  saved);
    end
    ready = 1'b1;
    tick(); chk("bp_next3", int'(a_sel), 3);
    tick(); chk("bp_next4", int'(a_sel), 4);

    // Manual interruption of a scan, then scan restarts from channel 0.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1;
    repeat (6) tick();
    chk("ms_scan5", int'(a_sel), 5);
    mode = 1'b0; sel = 3'd2; in_a = 8'b0000_0100;
    tick();
    chk("ms_man_sel", int'(a_sel), 2); chk("ms_man_data", int'(a_data), 1);
    mode = 1'b1;
    tick();
    chk("ms_restart_sel", int'(a_sel), 0); chk("ms_restart_valid", int'(a_valid), 1);

    // Asynchronous reset between edges while a beat is pending.
    chk("ar_pre_valid", int'(a_valid), 1);
    #3 rst = 1'b1;
    #1 check_zero("areset");
    model_reset();
    #1 rst = 1'b0;
    tick();
    chk("ar_first_sel", int'(a_sel), 0); chk("ar_first_valid", int'(a_valid), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 12 == 0) mode = ~mode;
      ready = ($urandom % 4) != 0;
      sel   = 3'($urandom);
      in_a  = 8'($urandom);
      in_b  = 5'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N-to-1 channel multiplexer. Successor to the combinational 8-to-1 mux.
- Adds two selection modes:
  - manual: the caller drives the channel select.
  - auto-scan: an internal round-robin pointer with a programmable dwell.
- Adds a registered valid/ready output stage, out-of-range select detection, and backpressure hold.
- Sits between a bank of sampled input channels and a single serial consumer, e.g. a monitor or logger.

Parameters:
- CHANNELS, 8, number of input channels; must be ≥2.
- WIDTH, 1, bits per channel.
- SEL_W, $clog2(CHANNELS), width of the select and pointer; derived, never overridden.
- DWELL, 1, cycles per channel in scan mode before a capture; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  CHANNELS*WIDTH  packed channels; channel k = in[k*WIDTH +: WIDTH].
- en  in  1  enables capture; 0 = idle.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  SEL_W  manual channel select.
- out_data  out  WIDTH  registered selected channel.
- out_sel  out  SEL_W  channel index that produced out_data.
- out_err  out  1  set with out_valid when the captured sel was ≥ CHANNELS.
- out_valid  out  1  out_data/out_sel/out_err are valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.

Behaviour:
- Reset: asynchronous on rst=1. Clears out_data, out_sel, out_err, out_valid, the scan pointer ptr and the dwell counter dcnt to 0. FSM goes to IDLE.
- Slot free: `free = !out_valid || out_ready`. A capture happens only when free, so back-to-back beats are allowed.
- Holding: when out_valid && !out_ready, all outputs, ptr and dcnt hold. There is no drop and no overwrite.
- FSM states: IDLE, MANUAL, SCAN. Evaluated every cycle:
  - en=0 → IDLE.
  - en=1 && mode=0 → MANUAL.
  - en=1 && mode=1 → SCAN.
- IDLE: no capture. On an out_ready handshake, out_valid drops to 0. ptr and dcnt hold.
- MANUAL: if free, capture on the next edge. Latency is 1 cycle from sel to out_data.
  - sel < CHANNELS: out_data = in[sel], out_err = 0.
  - sel ≥ CHANNELS: out_data = 0, out_err = 1.
  - In both cases out_sel = sel and out_valid = 1.
- SCAN: while free, dcnt increments each cycle.
  - When dcnt == DWELL-1 and free: capture in[ptr], out_sel = ptr, out_err = 0, out_valid = 1. Then dcnt ← 0 and ptr ← ptr+1, wrapping CHANNELS-1 → 0. The wrap is explicit, so it is correct for non-power-of-two CHANNELS.
  - With DWELL=1 a capture happens every free cycle: 0,1,…,CHANNELS-1,0,…
- Entering SCAN from any other state: ptr ← 0 and dcnt ← 0. The first capture occurs DWELL cycles after entry (assuming the slot is free).
- Leaving SCAN mid-dwell discards the partial dwell count.
- Simultaneous consume and capture (out_valid && out_ready && capture): the new beat replaces the old one in the same edge, and out_valid stays 1.
- Mode or en changes while stalled: the held beat is preserved. The new mode takes effect only once the beat is consumed.
- Reset mid-stream: the pending beat is lost and out_valid = 0 immediately (asynchronous).
- Input sampling: in is sampled only at the capture edge. Later changes to in do not affect a held out_data.

Decomposition:
- Package mux_scan_pkg: FSM state enum (IDLE/MANUAL/SCAN) and mode encoding constants (MODE_MANUAL=0, MODE_SCAN=1).
- One sub-module, mux_scan_ptr: owns the wrapping pointer and dwell counter, with inputs clear, advance-enable and free, and outputs ptr and fire.
- The datapath mux and the output register stay in mux_scan_n.

Test Plan (CHANNELS=8, WIDTH=1 unless noted):
- Manual basic: in=8'b10001010, out_ready=1, en=1, mode=0; sel=1,4,6,7 on consecutive cycles → out_data 1,0,0,1 one cycle later each, with out_sel matching and out_valid=1 throughout.
- Out-of-range: CHANNELS=5, sel=3'b110 → out_data=0, out_err=1, out_sel=6. Then sel=3'b100 → out_err=0, out_data=in[4].
- Scan wrap: CHANNELS=5, DWELL=2, mode=1, out_ready=1 → a capture every 2 cycles with out_sel 0,1,2,3,4,0,1. Entry to the first capture is 2 cycles.
- Backpressure: scan with DWELL=1 and out_ready=0 for 4 cycles after out_sel=2 → out_sel/out_data held at 2 and the pointer frozen. After out_ready=1, the next beats are 3,4,….
- Mode switch: scan reaches out_sel=5, then mode=0 with sel=2, then mode=1 again → manual beat with out_sel=2, then scan restarts at out_sel=0.
- Async reset: assert rst between clock edges while out_valid=1 → out_valid, out_data, out_sel and out_err go to 0 immediately. After release with en=1, mode=1, the first beat has out_sel=0.
